// File: rtl/sd_block_otf_converter.sv
// Radix-2^DIGITS signed-digit (p/n borrow-save) to two's-complement converter, MSD-first,
// using on-the-fly Q/QM conversion. Optional in_last checking under OTF_PROTOCOL_CHECK_EN.
module sd_block_otf_converter #(
    parameter int DIGITS = 8,
    parameter int NBLK   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGITS-1:0]          in_p,
    input  logic [DIGITS-1:0]          in_n,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGITS*NBLK:0]       out_data,
    output logic                       err
);
    localparam int W  = DIGITS * NBLK + 1;
    localparam int CW = $clog2(NBLK + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBLK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [W-1:0]          r_q;
    logic [W-1:0]          r_qm;
    logic [W-1:0]          w_q_nxt;
    logic [W-1:0]          w_qm_nxt;

    logic signed [DIGITS:0] w_d;
    logic                   w_pos;
    logic                   w_neg;
    logic [DIGITS-1:0]      w_fq;
    logic [DIGITS-1:0]      w_fqm;
    logic [W-1:0]           w_q_src;
    logic [W-1:0]           w_qm_src;
    logic [W-1:0]           w_q_shift;
    logic [W-1:0]           w_qm_shift;
    logic                   w_accept;

    assign w_d   = $signed({1'b0, in_p}) - $signed({1'b0, in_n});
    assign w_neg = w_d[DIGITS];
    assign w_pos = !w_d[DIGITS] && (|w_d);

    // The appended field is d mod r for Q and (d-1) mod r for QM whatever d's sign;
    // only the register being extended depends on the sign.
    assign w_fq       = w_d[DIGITS-1:0];
    assign w_fqm      = w_fq - 1'b1;
    assign w_q_src    = w_neg ? r_qm : r_q;
    assign w_qm_src   = w_pos ? r_q  : r_qm;
    assign w_q_shift  = {w_q_src[W-DIGITS-1:0], w_fq};
    assign w_qm_shift = {w_qm_src[W-DIGITS-1:0], w_fqm};

    assign w_accept = in_valid && in_ready;
    assign out_data = r_q;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_qm_nxt    = r_qm;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE, S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_q_nxt   = w_q_shift;
                    w_qm_nxt  = w_qm_shift;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_state == S_IDLE) begin
                        w_state_nxt = S_ACC;
                    end else if (r_cnt == LAST_CNT) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_q_nxt     = '0;
                    w_qm_nxt    = '1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_qm    <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_qm    <= w_qm_nxt;
        end
    end

`ifdef OTF_PROTOCOL_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && (in_last != (r_cnt == LAST_CNT))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_last;

    assign w_unused_last = in_last ^ w_accept;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_sd_block_otf_converter.sv
// Scoreboard bench for sd_block_otf_converter (DIGITS=8, NBLK=2): operand values are
// accumulated arithmetically as sum(d_k * r^k) and compared modulo 2^W.
module tb_sd_block_otf_converter;
    localparam int DIGITS = 8;
    localparam int NBLK   = 2;
    localparam int W      = DIGITS * NBLK + 1;
    localparam longint R  = longint'(1) << DIGITS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DIGITS-1:0] in_p;
    logic [DIGITS-1:0] in_n;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              err;

    sd_block_otf_converter #(.DIGITS(DIGITS), .NBLK(NBLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_n      (in_n),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] sb[$];
    longint       acc = 0;
    int           idx = 0;
    logic         exp_err = 1'b0;
    int           rdy_mode = 0;   // 0 random, 1 forced low, 2 forced high

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output side: randomise out_ready, check every presented word against the queue head
    always @(negedge clk) begin
        if (!rst_n) begin
            out_ready = 1'b0;
        end else begin
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(out_data), 64'(1'b0));
                end else begin
                    chk("out_data", 64'(out_data), 64'(sb[0]));
                    chk("in_ready_in_hold", 64'(in_ready), 64'(1'b0));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [DIGITS-1:0] p, input logic [DIGITS-1:0] n,
                        input logic last, output int waits);
        longint d;
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_p     = p;
        in_n     = n;
        in_last  = last;
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(waits), 64'(0));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d   = longint'(p) - longint'(n);
        acc = acc * R + d;
`ifdef OTF_PROTOCOL_CHECK_EN
        if (last != (idx == NBLK - 1)) exp_err = 1'b1;
`endif
        idx++;
        chk("qm_eq_q_minus_1", 64'(dut.r_qm), 64'(W'(dut.r_q - 1'b1)));
        chk("err", 64'(err), 64'(exp_err));
        if (idx == NBLK) begin
            sb.push_back(acc[W-1:0]);
            acc = 0;
            idx = 0;
            chk("latency_out_valid", 64'(out_valid), 64'(1'b1));
        end else begin
            chk("early_out_valid", 64'(out_valid), 64'(1'b0));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [DIGITS-1:0] p;
        logic [DIGITS-1:0] n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_p     = '0;
        in_n     = '0;
        in_last  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_err", 64'(err), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_qm", 64'(dut.r_qm), 64'({W{1'b1}}));
        rst_n = 1'b1;

        // +1,-1 -> 255 ; -255,-255 -> -65535 ; 0,-5 -> -5
        push(8'h01, 8'h00, 1'b0, w);
        push(8'h00, 8'h01, 1'b1, w);
        push(8'h00, 8'hFF, 1'b0, w);
        push(8'h00, 8'hFF, 1'b1, w);
        push(8'h00, 8'h00, 1'b0, w);
        push(8'h00, 8'h05, 1'b1, w);
        drain();

        // Backpressure: next operand's first block offered for 10 cycles into a stalled HOLD
        rdy_mode = 1;
        push(8'h3C, 8'h81, 1'b0, w);
        push(8'hA5, 8'h5A, 1'b1, w);
        fork
            push(8'h7F, 8'h80, 1'b0, w);
            begin
                repeat (10) @(posedge clk);
                #2 rdy_mode = 2;
            end
        join
        chk("bp_accept_wait", 64'(w), 64'(11));
        rdy_mode = 0;
        push(8'h12, 8'h34, 1'b1, w);
        drain();

        // in_last raised on the first block
        push(8'h10, 8'h00, 1'b1, w);
        push(8'h00, 8'h10, 1'b1, w);
        drain();
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(err), 64'(exp_err));

        // Reset mid-operand
        push(8'hC3, 8'h11, 1'b0, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        acc = 0;
        idx = 0;
        exp_err = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_cnt", 64'(dut.r_cnt), 64'(0));
        chk("mid_rst_err", 64'(err), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        push(8'h80, 8'h01, 1'b0, w);
        push(8'h02, 8'hF0, 1'b1, w);
        drain();

        // Random operands with random input gaps and zero digits mixed in
        for (int k = 0; k < 40; k++) begin
            for (int b = 0; b < NBLK; b++) begin
                p = DIGITS'($urandom);
                n = ($urandom_range(0, 5) == 0) ? p : DIGITS'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(p, n, (b == NBLK - 1), w);
            end
        end
        drain();
        chk("final_err", 64'(err), 64'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
